// File: rtl/maxpool_pkg.sv
// ============================================================================
// Module  : maxpool_pkg
// Brief   : float16 field constants and sortable-key helper for max-pooling.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package maxpool_pkg;

    localparam int           F16_W         = 16;
    localparam int           F16_SIGN_BIT  = 15;
    localparam logic [15:0]  F16_POS_ZERO  = 16'h0000;
    localparam logic [15:0]  F16_SIGN_FLIP = 16'h8000;

    // Maps sign-magnitude float16 onto an unsigned-comparable key:
    // negatives are inverted so larger magnitude sorts lower.
    function automatic logic [F16_W-1:0] f16_key(input logic [F16_W-1:0] x);
        return x[F16_SIGN_BIT] ? ~x : (x ^ F16_SIGN_FLIP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/f16_max2.sv
// ============================================================================
// Module  : f16_max2
// Brief   : combinational float16 maximum; ties resolve to input a.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module f16_max2
    import maxpool_pkg::*;
(
    input  logic [F16_W-1:0] a,
    input  logic [F16_W-1:0] b,
    output logic [F16_W-1:0] o_max
);

    logic [F16_W-1:0] w_key_a;
    logic [F16_W-1:0] w_key_b;

    assign w_key_a = f16_key(a);
    assign w_key_b = f16_key(b);

    // Strict compare keeps a on equal keys so its exact bit pattern survives.
    assign o_max = (w_key_b > w_key_a) ? b : a;

endmodule

`default_nettype wire

// File: rtl/maxpool_vec_f16.sv
// ============================================================================
// Module  : maxpool_vec_f16
// Brief   : NUM_CH-lane streaming float16 max-pool over runtime-length windows.
//           Optional macro MAXPOOL_RELU_EN clamps negative lane results to +0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module maxpool_vec_f16
    import maxpool_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int DATA_WIDTH = 16
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CNT_WIDTH-1:0]         win_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic                         busy
);

    localparam logic [CNT_WIDTH-1:0] C_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam int                   C_VECW = NUM_CH * F16_W;

    if (DATA_WIDTH != F16_W) begin : g_bad_width
        $error("maxpool_vec_f16: DATA_WIDTH must be 16 (float16 lanes only)");
    end

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_len;
    logic [C_VECW-1:0]    r_acc;
    logic [C_VECW-1:0]    r_out_data;
    logic                 r_out_valid;

    logic                 w_accept;
    logic                 w_first;
    logic                 w_last;
    logic [CNT_WIDTH-1:0] w_len_eff;
    logic [C_VECW-1:0]    w_max;
    logic [C_VECW-1:0]    w_next_acc;
    logic [C_VECW-1:0]    w_result;

    assign in_ready  = !(r_out_valid && !out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_first   = (r_cnt == '0);
    // A zero length is treated as a one-element window.
    assign w_len_eff = w_first ? ((win_len == '0) ? C_ONE : win_len) : r_len;
    assign w_last    = (r_cnt == (w_len_eff - C_ONE));

    assign w_next_acc = w_first ? in_data : w_max;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        f16_max2 u_max (
            .a     (r_acc  [k*F16_W +: F16_W]),
            .b     (in_data[k*F16_W +: F16_W]),
            .o_max (w_max  [k*F16_W +: F16_W])
        );
`ifdef MAXPOOL_RELU_EN
        assign w_result[k*F16_W +: F16_W] =
            w_next_acc[k*F16_W + F16_SIGN_BIT] ? F16_POS_ZERO : w_next_acc[k*F16_W +: F16_W];
`else
        assign w_result[k*F16_W +: F16_W] = w_next_acc[k*F16_W +: F16_W];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_len       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc <= w_next_acc;
                if (w_first) begin
                    r_len <= w_len_eff;
                end
                r_cnt <= w_last ? '0 : (r_cnt + C_ONE);
            end
            // A new result may load in the same cycle the previous one drains.
            if (w_accept && w_last) begin
                r_out_data  <= w_result;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_maxpool_vec_f16.sv
// ============================================================================
// Module  : tb_maxpool_vec_f16
// Brief   : directed scoreboard bench for maxpool_vec_f16 (NUM_CH=4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_maxpool_vec_f16;

    logic        clk;
    logic        rst;
    logic [7:0]  win_len;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int          n_tests   = 0;
    int          n_fail    = 0;
    int          xfer_cnt  = 0;
    int          cyc       = 0;
    int          last_xfer = 0;
    int          prev_xfer = 0;
    logic [63:0] sb[$];

    maxpool_vec_f16 #(
        .NUM_CH     (4),
        .CNT_WIDTH  (8),
        .DATA_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .win_len   (win_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [63:0] expv(input logic [63:0] v);
        logic [63:0] r;
        r = v;
`ifdef MAXPOOL_RELU_EN
        for (int k = 0; k < 4; k++)
            if (r[16*k+15]) r[16*k +: 16] = 16'h0000;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] v);
        sb.push_back(expv(v));
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] wl);
        int budget;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        win_len  = wl;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            chk("send_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor: every output transfer is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            xfer_cnt++;
            prev_xfer = last_xfer;
            last_xfer = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_output", out_data, 64'hxxxx_xxxx_xxxx_xxxx);
            end else begin
                chk("out_data", out_data, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int xb;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; win_len = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  out_data,       64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        rst = 1'b1;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Window of 4 with mixed normals, subnormals and specials.
        send(64'h7C00_C000_0001_3C00, 8'd4);
        chk("first_busy", 64'(busy), 64'd1);
        send(64'h7E00_C400_0002_4000, 8'd4);
        send(64'h0000_BC00_8001_BC00, 8'd4);
        chk("pre_last_valid", 64'(out_valid), 64'd0);
        push(64'h7E00_BC00_0002_4000);
        send(64'hFC00_C200_0000_3800, 8'd4);
        chk("latency_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 chk("valid_pulse", 64'(out_valid), 64'd0);

        // Single-element windows back to back.
        xb = xfer_cnt;
        push(64'h0001_8000_3C00_C500); send(64'h0001_8000_3C00_C500, 8'd0);
        push(64'h7BFF_0400_FBFF_C500); send(64'h7BFF_0400_FBFF_C500, 8'd1);
        push(64'h0000_0000_0000_4400); send(64'h0000_0000_0000_4400, 8'd1);
        @(negedge clk); #1;
        chk("burst_xfers", 64'(xfer_cnt - xb), 64'd3);
        chk("no_bubble", 64'(last_xfer - prev_xfer), 64'd1);

        // Signed zeros, infinities, NaNs and ties.
        send(64'h3C00_7E00_FC00_8000, 8'd2);
        push(64'h3C00_7E00_7C00_0000);
        send(64'h3C00_7C00_7C00_0000, 8'd2);
        send(64'h8000_FE00_7C00_0000, 8'd2);
        push(64'h8000_FC00_7C00_0000);
        send(64'h8000_FC00_FC00_8000, 8'd2);

        // Backpressure: result held, input stalled, single transfer on release.
        @(posedge clk); #1 out_ready = 1'b0;
        send(64'h1234_0001_C000_4000, 8'd2);
        push(64'h1234_0002_C000_4000);
        send(64'h1000_0002_C100_3000, 8'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_data",  out_data,       expv(64'h1234_0002_C000_4000));
            chk("hold_ready", 64'(in_ready),  64'd0);
        end
        xb = xfer_cnt;
        @(posedge clk); #1 out_ready = 1'b1;
        #1 chk("release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_xfers", 64'(xfer_cnt - xb), 64'd1);

        // Mid-window win_len change is ignored until the next window.
        send(64'h0000_0000_0000_3C00, 8'd4);
        send(64'h0000_0000_0000_4000, 8'd2);
        chk("len_change_hold", 64'(out_valid), 64'd0);
        send(64'h0000_0000_0000_4200, 8'd2);
        push(64'h0000_0000_0000_4400);
        send(64'h0000_0000_0000_4400, 8'd2);
        chk("len_change_close", 64'(out_valid), 64'd1);
        send(64'h0000_0000_0000_4800, 8'd2);
        push(64'h0000_0000_0000_4800);
        send(64'h0000_0000_0000_4600, 8'd2);

        // Reset mid-window discards the partial window.
        send(64'h7C00_7C00_7C00_5000, 8'd4);
        send(64'h7C00_7C00_7C00_5000, 8'd4);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy",  64'(busy),      64'd0);
        chk("midrst_data",  out_data,       64'd0);
        @(posedge clk); #1 rst = 1'b1;
        send(64'h8000_3C00_BC00_C000, 8'd4);
        send(64'h0000_3800_C000_BC00, 8'd4);
        send(64'h8001_3400_C000_C200, 8'd4);
        push(64'h0001_4000_BC00_BC00);
        send(64'h0001_4000_C000_C400, 8'd4);

        repeat (5) @(posedge clk);
        #1 chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
